apb_req_arbiter: RTL and testbench

- Shares one APB master port among NUM_REQ internal requesters, e.g. register sequencer, DMA config and debug port.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- Returns completion and read data to the winning requester.
- Sits between the register-access agents and the APB bus whose signals appear on ral_interface, with psel/penable/pwrite/paddr/pwdata/prdata.

---
 rtl/apb_req_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Optional macro APB_TIMEOUT_EN adds an ACCESS wait-state timeout that aborts with err.
module apb_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("apb_req_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
    logic [IDX_W-1:0]    arb_win;
    logic                arb_found;
    logic [IDX_W:0]      cand;

    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!arb_found && req[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = cand[IDX_W-1:0];
            end
        end
    end

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_win == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    // Pointer after the current winner completes: that requester becomes lowest priority.
    logic [IDX_W:0]      rr_wrap;
    logic [IDX_W-1:0]    rr_next;

    always_comb begin
        rr_wrap = {1'b0, win_q} + (IDX_W+1)'(1);
        if (rr_wrap == (IDX_W+1)'(NUM_REQ)) begin
            rr_wrap = '0;
        end
        rr_next = rr_wrap[IDX_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        win_d     = win_q;
        gnt_d     = '0;
        done_d    = '0;
        rdata_d   = rdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d          = arb_win;
                    gnt_d[arb_win] = 1'b1;
                    paddr_d        = sel_addr;
                    pwdata_d       = sel_wdata;
                    pwrite_d       = sel_write;
                    psel_d         = 1'b1;
                    penable_d      = 1'b0;
                    state_d        = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    done_d[win_q] = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                    rr_d    = rr_next;
                    state_d = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    done_d[win_q] = 1'b1;
                    err_d         = 1'b1;
                    rdata_d       = '0;
                    rr_d          = rr_next;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also aborts any transfer in flight without a done pulse.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
`ifdef APB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NUM_REQ=2); outputs sampled 1ns after each rising edge.
module tb_apb_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      pclk;
    logic                      preset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;

    int n_checks = 0;
    int n_fails  = 0;

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)
    ) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        preset    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b1;
        tick();
        tick();

        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_psel_pen", {30'b0, psel, penable}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err_pwrite", {30'b0, err, pwrite}, 32'h0);
        preset = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Single read from requester 0, zero-wait slave.
        req[0]                = 1'b1;
        req_write[0]          = 1'b0;
        req_addr[0*ADDR_W +: ADDR_W] = 32'h0000_0010;
        prdata                = 32'hDEAD_BEEF;
        pready                = 1'b1;
        tick();
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_setup_psel_pen", {30'b0, psel, penable}, 32'h2);
        chk("rd_paddr", paddr, 32'h10);
        chk("rd_pwrite", 32'(pwrite), 32'h0);
        req = '0;
        tick();
        chk("rd_access_psel_pen", {30'b0, psel, penable}, 32'h3);
        chk("rd_gnt_cleared", 32'(gnt), 32'h0);
        chk("rd_no_done_yet", 32'(done), 32'h0);
        tick();
        chk("rd_done", 32'(done), 32'h1);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd_err", 32'(err), 32'h0);
        chk("rd_end_psel_pen", {30'b0, psel, penable}, 32'h0);
        chk("rd_gnt_in_done", 32'(gnt), 32'h0);
        tick();
        chk("rd_done_pulse", 32'(done), 32'h0);

        // Write from requester 1 with three wait states.
        req[1]       = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1*ADDR_W +: ADDR_W]  = 32'h0000_0024;
        req_wdata[1*DATA_W +: DATA_W] = 32'h1234_5678;
        req_addr[0*ADDR_W +: ADDR_W]  = 32'h0000_0BAD;
        prdata       = 32'hCAFE_0000;
        pready       = 1'b0;
        tick();
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_pwrite", 32'(pwrite), 32'h1);
        req       = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        chk("wr_penable", 32'(penable), 32'h1);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("wr_wait_paddr", paddr, 32'h24);
            chk("wr_wait_pwdata", pwdata, 32'h1234_5678);
            chk("wr_wait_ctrl", {29'b0, psel, penable, pwrite}, 32'h7);
            chk("wr_wait_done", 32'(done), 32'h0);
        end
        pready = 1'b1;
        tick();
        chk("wr_done", 32'(done), 32'h2);
        chk("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
        chk("wr_end_psel", 32'(psel), 32'h0);
        chk("wr_paddr_held", paddr, 32'h24);
        chk("wr_pwdata_held", pwdata, 32'h1234_5678);

        // Both requesting continuously: grants alternate, one per three edges.
        req       = 2'b11;
        req_write = 2'b00;
        prdata    = 32'h0000_1111;
        for (int t = 1; t <= 12; t++) begin
            tick();
            case (t)
                1, 7:    chk("cont_gnt", 32'(gnt), 32'h1);
                4, 10:   chk("cont_gnt", 32'(gnt), 32'h2);
                default: chk("cont_gnt", 32'(gnt), 32'h0);
            endcase
            case (t)
                3, 9:    chk("cont_done", 32'(done), 32'h1);
                6, 12:   chk("cont_done", 32'(done), 32'h2);
                default: chk("cont_done", 32'(done), 32'h0);
            endcase
        end
        chk("cont_rdata", rdata, 32'h0000_1111);
        req = '0;

        // Requester 1 pulses while requester 0 is in flight, then withdraws.
        req[0] = 1'b1;
        tick();
        chk("wd_gnt0", 32'(gnt), 32'h1);
        req = 2'b10;
        tick();
        req = 2'b00;
        tick();
        chk("wd_done0", 32'(done), 32'h1);
        tick();
        chk("wd_no_gnt1", 32'(gnt), 32'h0);
        chk("wd_idle_psel", 32'(psel), 32'h0);
        tick();
        chk("wd_no_gnt1_b", 32'(gnt), 32'h0);

        // Reset during ACCESS; pointer currently favours requester 1.
        req    = 2'b01;
        pready = 1'b0;
        tick();
        chk("rst_mid_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("rst_mid_penable", 32'(penable), 32'h1);
        preset = 1'b1;
        tick();
        chk("rst_mid_psel_pen", {30'b0, psel, penable}, 32'h0);
        chk("rst_mid_no_done", 32'(done), 32'h0);
        preset = 1'b0;
        pready = 1'b1;
        tick();
        chk("rst_mid_idle_done", 32'(done), 32'h0);
        req = 2'b11;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();
        chk("post_rst_done", 32'(done), 32'h1);

`ifdef APB_TIMEOUT_EN
        // Read that never sees pready: aborted after TIMEOUT_CYC wait cycles.
        req    = 2'b01;
        pready = 1'b0;
        prdata = 32'h5555_AAAA;
        tick();
        chk("to_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        for (int w = 0; w < 16; w++) begin
            tick();
            chk("to_wait_done", 32'(done), 32'h0);
        end
        tick();
        chk("to_done", 32'(done), 32'h1);
        chk("to_err", 32'(err), 32'h1);
        chk("to_rdata", rdata, 32'h0);
        chk("to_psel", 32'(psel), 32'h0);
        tick();
        chk("to_err_clear", 32'(err), 32'h0);
        pready = 1'b1;
`else
        // Without the timeout a stalled slave simply holds the transfer open.
        req    = 2'b01;
        pready = 1'b0;
        tick();
        req = '0;
        tick();
        for (int w = 0; w < 20; w++) begin
            tick();
            chk("stall_done", 32'(done), 32'h0);
            chk("stall_err", 32'(err), 32'h0);
        end
        chk("stall_penable", 32'(penable), 32'h1);
        pready = 1'b1;
        tick();
        chk("stall_done_end", 32'(done), 32'h1);
        chk("stall_err_end", 32'(err), 32'h0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
